// File: rtl/pulse_xfer_sched_pkg.sv
// Shared definitions for the pulse transfer scheduler: FSM state encoding,
// default ID width and the timer-width helper.
package pulse_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } xfer_state_e;

    localparam int N_REQ_DFLT = 4;
    localparam int ID_W       = $clog2(N_REQ_DFLT);

    // The timer only ever holds (length - 1), so clog2 of the largest length suffices.
    function automatic int tmr_width(input int hold_cyc, input int gap_cyc, input int ack_tmo);
        int m;
        m = hold_cyc;
        if (gap_cyc > m) begin
            m = gap_cyc;
        end
        if (ack_tmo > m) begin
            m = ack_tmo;
        end
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pulse_xfer_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// strictly after the pointer position, wrapping around.
module rr_arbiter
    import pulse_xfer_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               pos_s;
    logic [IDX_W-1:0] pos_idx_s;
    logic             found_s;

    // Scan from ptr+1 around the ring and take the first pending requester
    always_comb begin
        gnt_o     = '0;
        idx_o     = '0;
        found_s   = 1'b0;
        pos_s     = 0;
        pos_idx_s = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            pos_s     = (int'(ptr_i) + i) % N_REQ;
            pos_idx_s = IDX_W'(pos_s);
            if (!found_s && req_i[pos_idx_s]) begin
                found_s           = 1'b1;
                gnt_o[pos_idx_s]  = 1'b1;
                idx_o             = pos_idx_s;
            end else begin
                found_s = found_s;
            end
        end
        any_o = found_s;
    end

endmodule

// File: rtl/pulse_xfer_sched.sv
// Source-domain scheduler sharing one pulse synchronizer among N_REQ
// requesters. Pending events are counted per requester, granted round-robin,
// and emitted as a stretched pulse plus ID followed by a guard gap.
// Optional feature macro: PULSE_XFER_ACK_EN adds ack_i and a WAIT_ACK state
// with timeout strobe on tmo_o.
module pulse_xfer_sched
    import pulse_xfer_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CNT_W    = 3,
    parameter int HOLD_CYC = 3,
    parameter int GAP_CYC  = 2,
    parameter int ACK_TMO  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     clr_ovf_i,
`ifdef PULSE_XFER_ACK_EN
    input  logic                     ack_i,
`endif
    output logic                     xfer_pulse_o,
    output logic [$clog2(N_REQ)-1:0] xfer_id_o,
    output logic                     busy_o,
    output logic [N_REQ-1:0]         pend_o,
    output logic [N_REQ-1:0]         ovf_o,
    output logic                     tmo_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = tmr_width(HOLD_CYC, GAP_CYC, ACK_TMO);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    // With no guard gap the FSM returns straight to arbitration after the pulse.
    localparam xfer_state_e      POST_ST   = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
`ifdef PULSE_XFER_ACK_EN
    localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'((ACK_TMO > 0) ? ACK_TMO - 1 : 0);
`endif

    xfer_state_e      state_q, state_d;
    logic             pulse_q, pulse_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             tmo_q, tmo_d;
    logic [N_REQ-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    logic [N_REQ-1:0] nz_s;
    logic [N_REQ-1:0] arb_gnt_s;
    logic [IDX_W-1:0] arb_idx_s;
    logic             arb_any_s;
    logic             grant_fire_s;
    logic [N_REQ-1:0] dec_s;
    logic [N_REQ-1:0] ovf_set_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (nz_s),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .any_o (arb_any_s)
    );

    assign dec_s = grant_fire_s ? arb_gnt_s : {N_REQ{1'b0}};

    for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
        logic [CNT_W-1:0] nxt_s;
        logic             sat_s;

        // Saturating pending-event counter; a simultaneous event and grant cancel out
        always_comb begin
            nxt_s = cnt_q[k];
            sat_s = 1'b0;
            if (req_i[k] && !dec_s[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    sat_s = 1'b1;
                end else begin
                    nxt_s = cnt_q[k] + CNT_W'(1);
                end
            end else if (!req_i[k] && dec_s[k]) begin
                nxt_s = cnt_q[k] - CNT_W'(1);
            end else begin
                nxt_s = cnt_q[k];
            end
        end

        assign cnt_d[k]     = nxt_s;
        assign ovf_set_s[k] = sat_s;
        assign nz_s[k]      = (cnt_q[k] != {CNT_W{1'b0}});
    end

    // Clear loses to a fresh overflow on the same bit
    assign ovf_d = (clr_ovf_i ? {N_REQ{1'b0}} : ovf_q) | ovf_set_s;

    // Scheduler FSM: arbitrate, hold the pulse, optionally await ack, then guard gap
    always_comb begin
        state_d      = state_q;
        pulse_d      = pulse_q;
        id_d         = id_q;
        ptr_d        = ptr_q;
        tmr_d        = tmr_q;
        tmo_d        = 1'b0;
        grant_fire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    grant_fire_s = 1'b1;
                    state_d      = ST_HOLD;
                    pulse_d      = 1'b1;
                    id_d         = arb_idx_s;
                    ptr_d        = arb_idx_s;
                    tmr_d        = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (tmr_q == {TMR_W{1'b0}}) begin
                    pulse_d = 1'b0;
`ifdef PULSE_XFER_ACK_EN
                    state_d = ST_WAIT_ACK;
                    tmr_d   = ACK_LOAD;
`else
                    state_d = POST_ST;
                    tmr_d   = GAP_LOAD;
`endif
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_WAIT_ACK: begin
`ifdef PULSE_XFER_ACK_EN
                if (ack_i) begin
                    state_d = POST_ST;
                    tmr_d   = GAP_LOAD;
                end else if (tmr_q == {TMR_W{1'b0}}) begin
                    tmo_d   = 1'b1;
                    state_d = POST_ST;
                    tmr_d   = GAP_LOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_GAP: begin
                if (tmr_q == {TMR_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
            end
        endcase
    end

    // State, counters and flags; reset discards any in-flight and pending events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
            id_q    <= {IDX_W{1'b0}};
            ptr_q   <= IDX_W'(N_REQ - 1);
            tmr_q   <= {TMR_W{1'b0}};
            tmo_q   <= 1'b0;
            ovf_q   <= {N_REQ{1'b0}};
            for (int k = 0; k < N_REQ; k++) begin
                cnt_q[k] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            tmo_q   <= tmo_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign xfer_pulse_o = pulse_q;
    assign xfer_id_o    = id_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign pend_o       = nz_s;
    assign ovf_o        = ovf_q;
    assign tmo_o        = tmo_q;

endmodule

// File: tb/tb_pulse_xfer_sched.sv
// Scoreboard bench for pulse_xfer_sched (default build, timed operation).
// A schedule-level reference model predicts grants, pending state and flags;
// a negedge monitor compares the DUT against it.
module tb_pulse_xfer_sched;

    localparam int N    = 4;
    localparam int HOLD = 3;
    localparam int GAP  = 2;
    localparam int SAT  = 7;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] req     = 4'b0000;
`ifdef PULSE_XFER_ACK_EN
    logic       ack     = 1'b0;
`endif

    logic       xfer_pulse_o;
    logic [1:0] xfer_id_o;
    logic       busy_o;
    logic [3:0] pend_o;
    logic [3:0] ovf_o;
    logic       tmo_o;

    pulse_xfer_sched #(
        .N_REQ    (N),
        .CNT_W    (3),
        .HOLD_CYC (HOLD),
        .GAP_CYC  (GAP),
        .ACK_TMO  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .clr_ovf_i    (clr_ovf),
`ifdef PULSE_XFER_ACK_EN
        .ack_i        (ack),
`endif
        .xfer_pulse_o (xfer_pulse_o),
        .xfer_id_o    (xfer_id_o),
        .busy_o       (busy_o),
        .pend_o       (pend_o),
        .ovf_o        (ovf_o),
        .tmo_o        (tmo_o)
    );

    always #5 clk = ~clk;

    // Reference model state (after the most recent clock edge)
    int       cyc      = 0;
    int       pend [N];
    bit [3:0] m_ovf    = 4'b0000;
    int       ptr      = N - 1;
    int       free_at  = 0;
    int       last_gnt = -100;
    int       last_id  = 0;

    typedef struct {
        int id;
        int edge_n;
    } exp_t;
    exp_t exp_q [$];

    int   n_vec = 0;
    int   n_err = 0;
    logic prev_pulse = 1'b0;
    exp_t mon_e;
    logic [3:0] mon_ev;

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, expv);
        end
    endtask

    // Schedule-level model: one arbitration slot every HOLD+GAP+1 cycles
    task automatic model_step();
        int       g;
        int       k;
        bit [3:0] nov;
        exp_t     e;
        cyc++;
        if (!rst_n) begin
            for (int j = 0; j < N; j++) pend[j] = 0;
            m_ovf    = 4'b0000;
            ptr      = N - 1;
            free_at  = cyc + 1;
            last_gnt = -100;
            last_id  = 0;
            exp_q.delete();
        end else begin
            g = -1;
            if (cyc >= free_at) begin
                for (int i = 1; i <= N; i++) begin
                    k = (ptr + i) % N;
                    if (g < 0 && pend[k] > 0) g = k;
                end
                if (g >= 0) begin
                    ptr      = g;
                    last_id  = g;
                    last_gnt = cyc;
                    free_at  = cyc + HOLD + GAP + 1;
                    e.id     = g;
                    e.edge_n = cyc;
                    exp_q.push_back(e);
                end
            end
            nov = clr_ovf ? 4'b0000 : m_ovf;
            for (int j = 0; j < N; j++) begin
                if (req[j] && g != j) begin
                    if (pend[j] == SAT) nov[j] = 1'b1;
                    else pend[j]++;
                end else if (!req[j] && g == j) begin
                    pend[j]--;
                end
            end
            m_ovf = nov;
        end
    endtask

    always @(posedge clk) model_step();

    // Monitor: compare DUT outputs with the model away from the active edge
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int j = 0; j < N; j++) mon_ev[j] = (pend[j] > 0);
            chk("pulse", int'(xfer_pulse_o), int'((cyc >= last_gnt) && (cyc - last_gnt < HOLD)));
            chk("id", int'(xfer_id_o), last_id);
            chk("busy", int'(busy_o), int'(cyc + 1 < free_at));
            chk("pend", int'(pend_o), int'(mon_ev));
            chk("ovf", int'(ovf_o), int'(m_ovf));
            chk("tmo", int'(tmo_o), 0);
            if (xfer_pulse_o && !prev_pulse) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rise_unexpected cyc=%0d got id=%0d expected no pulse", cyc, xfer_id_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rise_id", int'(xfer_id_o), mon_e.id);
                    chk("rise_cyc", cyc, mon_e.edge_n);
                end
            end
            prev_pulse = xfer_pulse_o;
        end
    end

    task automatic step(input logic [3:0] r, input logic c, input logic rs);
        req     = r;
        clr_ovf = c;
        rst_n   = rs;
        @(negedge clk);
    endtask

    logic [3:0] rr;
    logic       rc;
    logic       rrs;

    initial begin
        for (int j = 0; j < N; j++) pend[j] = 0;
        repeat (2) @(negedge clk);

        // Single event on requester 2
        step(4'b0100, 1'b0, 1'b1);
        repeat (12) step(4'b0000, 1'b0, 1'b1);

        // Fairness: all four at once
        step(4'b1111, 1'b0, 1'b1);
        repeat (26) step(4'b0000, 1'b0, 1'b1);

        // Saturation on requester 1, then clear colliding with a new overflow
        repeat (14) step(4'b0010, 1'b0, 1'b1);
        step(4'b0010, 1'b1, 1'b1);
        repeat (2) step(4'b0010, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        repeat (60) step(4'b0000, 1'b0, 1'b1);

        // Event arriving on its own grant edge
        step(4'b0001, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b1);
        repeat (16) step(4'b0000, 1'b0, 1'b1);

        // Reset during the second pulse cycle
        step(4'b0001, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        repeat (12) step(4'b0000, 1'b0, 1'b1);

        // Randomized traffic with occasional clears and resets
        repeat (400) begin
            rr  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            rc  = ($urandom_range(0, 15) == 0);
            rrs = ($urandom_range(0, 199) != 0);
            step(rr, rc, rrs);
        end

        // Drain everything still pending
        repeat (200) step(4'b0000, 1'b0, 1'b1);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d outstanding grants expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
